// File: rtl/naive_ntt_pkg.sv
// rtl/naive_ntt_pkg.sv - shared sizes, state encoding and vector helpers for the naive NTT pair
package naive_ntt_pkg;

  localparam int N    = 8;
  localparam int W    = 8;
  localparam int IDXW = $clog2(N);

  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(N - 1);

  typedef logic [W-1:0]   coef_t;
  typedef logic [N*W-1:0] vec_t;

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    SCALE,
    DONE
  } state_e;

  function automatic coef_t get_coef(input vec_t v, input logic [IDXW-1:0] idx);
    return v[idx*W +: W];
  endfunction

  function automatic vec_t set_coef(input vec_t v, input logic [IDXW-1:0] idx, input coef_t c);
    vec_t r;
    r = v;
    r[idx*W +: W] = c;
    return r;
  endfunction

  // q == 0 has no residues; map everything to 0 so the datapath stays defined
  function automatic coef_t mod_reduce(input coef_t x, input coef_t q);
    return (q == '0) ? '0 : coef_t'(x % q);
  endfunction

endpackage

// File: rtl/mod_mulmod.sv
// rtl/mod_mulmod.sv - combinational a*b mod q with a full 2W-bit product
module mod_mulmod
  import naive_ntt_pkg::*;
(
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] q_i,
  output logic [W-1:0] r_o
);

  logic [2*W-1:0] prod;
  logic [2*W-1:0] rem;

  assign prod = a_i * b_i;

  always_comb begin
    rem = '0;
    if (q_i != '0) begin
      rem = prod % {{W{1'b0}}, q_i};
    end
  end

  assign r_o = rem[W-1:0];

endmodule

// File: rtl/naive_intt_seq.sv
// rtl/naive_intt_seq.sv - sequential 8-point inverse NTT, one multiply-accumulate per cycle
module naive_intt_seq
  import naive_ntt_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] data_in,
  input  logic [W-1:0]   omega_inv,
  input  logic [W-1:0]   n_inv,
  input  logic [W-1:0]   mod,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*W-1:0] data_out,
  output logic           busy
);

  state_e          state_q, state_d;
  coef_t           x_in_q [N];
  coef_t           x_in_d [N];
  coef_t           acc_q, acc_d;
  coef_t           tw_q, tw_d;
  coef_t           step_q, step_d;
  coef_t           oinv_q, oinv_d;
  coef_t           ninv_q, ninv_d;
  coef_t           q_q, q_d;
  logic [IDXW-1:0] i_q, i_d;
  logic [IDXW-1:0] j_q, j_d;
  vec_t            res_q, res_d;

  coef_t     prod_xt, prod_sh, prod_sc;
  coef_t     sh_a, sh_b;
  coef_t     one_q, one_in;
  logic [W:0] sum;

  mod_mulmod u_mul_xt (.a_i(x_in_q[j_q]), .b_i(tw_q), .q_i(q_q), .r_o(prod_xt));

  // one multiplier advances the twiddle in COMPUTE and the row step in SCALE
  assign sh_a = (state_q == SCALE) ? step_q : tw_q;
  assign sh_b = (state_q == SCALE) ? oinv_q : step_q;
  mod_mulmod u_mul_sh (.a_i(sh_a), .b_i(sh_b), .q_i(q_q), .r_o(prod_sh));

  mod_mulmod u_mul_sc (.a_i(acc_q), .b_i(ninv_q), .q_i(q_q), .r_o(prod_sc));

  assign sum    = {1'b0, acc_q} + {1'b0, prod_xt};
  assign one_q  = (q_q >= coef_t'(2)) ? coef_t'(1) : '0;
  assign one_in = (mod >= coef_t'(2)) ? coef_t'(1) : '0;

  always_comb begin
    state_d = state_q;
    x_in_d  = x_in_q;
    acc_d   = acc_q;
    tw_d    = tw_q;
    step_d  = step_q;
    oinv_d  = oinv_q;
    ninv_d  = ninv_q;
    q_d     = q_q;
    i_d     = i_q;
    j_d     = j_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          for (int k = 0; k < N; k++) begin
            x_in_d[k] = mod_reduce(get_coef(data_in, IDXW'(k)), mod);
          end
          oinv_d  = mod_reduce(omega_inv, mod);
          ninv_d  = mod_reduce(n_inv, mod);
          q_d     = mod;
          i_d     = '0;
          j_d     = '0;
          acc_d   = '0;
          tw_d    = one_in;
          step_d  = one_in;
          state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        acc_d = (sum >= {1'b0, q_q}) ? coef_t'(sum - {1'b0, q_q}) : coef_t'(sum);
        tw_d  = prod_sh;
        j_d   = j_q + 1'b1;
        if (j_q == IDX_LAST) begin
          state_d = SCALE;
        end
      end
      SCALE: begin
        res_d   = set_coef(res_q, i_q, prod_sc);
        step_d  = prod_sh;
        acc_d   = '0;
        tw_d    = one_q;
        j_d     = '0;
        i_d     = i_q + 1'b1;
        state_d = (i_q == IDX_LAST) ? DONE : COMPUTE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      for (int k = 0; k < N; k++) begin
        x_in_q[k] <= '0;
      end
      acc_q  <= '0;
      tw_q   <= '0;
      step_q <= '0;
      oinv_q <= '0;
      ninv_q <= '0;
      q_q    <= '0;
      i_q    <= '0;
      j_q    <= '0;
      res_q  <= '0;
    end else begin
      state_q <= state_d;
      x_in_q  <= x_in_d;
      acc_q   <= acc_d;
      tw_q    <= tw_d;
      step_q  <= step_d;
      oinv_q  <= oinv_d;
      ninv_q  <= ninv_d;
      q_q     <= q_d;
      i_q     <= i_d;
      j_q     <= j_d;
      res_q   <= res_d;
    end
  end

  // gated by rst_n so the block never advertises ready while held in reset
  assign in_ready  = (state_q == IDLE) && rst_n;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == COMPUTE) || (state_q == SCALE);
  assign data_out  = res_q;

endmodule

// File: tb/tb_naive_intt_seq.sv
// tb/tb_naive_intt_seq.sv - scoreboard bench for naive_intt_seq with directed vectors
module tb_naive_intt_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] data_in = '0;
  logic [7:0]  omega_inv = '0;
  logic [7:0]  n_inv = '0;
  logic [7:0]  mod = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] data_out;
  logic        busy;

  naive_intt_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .omega_inv(omega_inv), .n_inv(n_inv), .mod(mod),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out), .busy(busy)
  );

  always #5 clk = ~clk;

  localparam logic [63:0] X_E0    = 64'd1;
  localparam logic [63:0] X_ONES  = {8{8'd1}};
  localparam logic [63:0] X_E1    = 64'h0000_0000_0000_0100;
  localparam logic [63:0] X_E4_3  = 64'h0000_0003_0000_0000;
  localparam logic [63:0] X_18    = 64'd18;
  localparam logic [63:0] R_E0    = {8{8'd15}};
  localparam logic [63:0] R_ONES  = 64'd1;
  localparam logic [63:0] R_E1    = {8'd13, 8'd9, 8'd1, 8'd2, 8'd4, 8'd8, 8'd16, 8'd15};
  localparam logic [63:0] R_E4_3  = {4{8'd6, 8'd11}};

  int n_chk = 0;
  int n_pass = 0;
  int pcyc = 0;
  logic [63:0] exp_q[$];
  int          hs_q[$];
  logic [63:0] mon_e;
  int          mon_h;
  logic        prev_ov = 1'b0;

  always @(posedge clk) pcyc <= pcyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  always @(negedge clk) begin
    if (out_valid && !prev_ov) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        mon_h = hs_q.pop_front();
        chk("data_out", data_out, mon_e);
        chk("latency", 64'(pcyc - mon_h), 64'd72);
      end
    end
    prev_ov <= out_valid;
  end

  task automatic send(input logic [63:0] x, input logic [7:0] om, input logic [7:0] ni,
                      input logic [7:0] q, input logic [63:0] e);
    int t = 0;
    @(negedge clk);
    while (!in_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 64'd0, 64'd1);
      return;
    end
    data_in = x; omega_inv = om; n_inv = ni; mod = q; in_valid = 1'b1;
    exp_q.push_back(e);
    hs_q.push_back(pcyc + 1);
    @(negedge clk);
    in_valid = 1'b0;
    data_in = 64'hdead_beef_1234_5678; omega_inv = 8'h55; n_inv = 8'haa; mod = 8'h03;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || out_valid) && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_data_out", data_out, 64'd0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    send(X_E0, 8'd9, 8'd15, 8'd17, R_E0);
    drain();
    send(X_ONES, 8'd9, 8'd15, 8'd17, R_ONES);
    send(X_E1, 8'd9, 8'd15, 8'd17, R_E1);
    send(X_E4_3, 8'd9, 8'd15, 8'd17, R_E4_3);
    send(X_18, 8'd9, 8'd15, 8'd17, R_E0);
    send(X_E0, 8'd9, 8'd15, 8'd1, 64'd0);
    drain();

    // hold the result for 20 cycles, then offer a new vector in the release cycle
    out_ready = 1'b0;
    send(X_E1, 8'd9, 8'd15, 8'd17, R_E1);
    begin
      int t = 0;
      while (!out_valid && t < 300) begin
        @(negedge clk);
        t++;
      end
      chk("bp_out_valid_seen", 64'(out_valid), 64'd1);
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_data_out", data_out, R_E1);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    data_in = X_ONES; omega_inv = 8'd9; n_inv = 8'd15; mod = 8'd17;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("rel_out_valid", 64'(out_valid), 64'd0);
    chk("rel_in_ready", 64'(in_ready), 64'd1);
    chk("rel_busy", 64'(busy), 64'd0);

    send(X_ONES, 8'd9, 8'd15, 8'd17, R_ONES);
    repeat (29) @(negedge clk);
    chk("mid_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
    chk("mid_rst_data_out", data_out, 64'd0);
    exp_q.delete();
    hs_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    send(X_E1, 8'd9, 8'd15, 8'd17, R_E1);
    drain();
    repeat (5) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
